// File: rtl/ureg_pkg.sv
// Shared op-code and state definitions for the universal register and its shift step.
package ureg_pkg;
  localparam int OP_W = 3;
  typedef logic [OP_W-1:0] op_t;

  localparam op_t OP_INC = 3'd0;
  localparam op_t OP_DEC = 3'd1;
  localparam op_t OP_SHL = 3'd2;
  localparam op_t OP_SHR = 3'd3;
  localparam op_t OP_ASR = 3'd4;
  localparam op_t OP_ROL = 3'd5;
  localparam op_t OP_ROR = 3'd6;
  localparam op_t OP_NOP = 3'd7;

  typedef enum logic {ST_IDLE, ST_SHIFT} state_e;
endpackage

// File: rtl/universal_register_if.sv
// Control/status bundle of the universal register; master drives requests, slave is the register.
interface universal_register_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH+1)
);
  import ureg_pkg::*;

  logic                   cl;
  logic                   ld;
  logic [DATA_WIDTH-1:0]  in;
  logic                   start;
  op_t                    op;
  logic [SHAMT_WIDTH-1:0] shamt;
  logic                   ser_in;
  logic [DATA_WIDTH-1:0]  out;
  logic                   cy;
  logic                   busy;
  logic                   done;

  modport master (output cl, ld, in, start, op, shamt, ser_in,
                  input  out, cy, busy, done);
  modport slave  (input  cl, ld, in, start, op, shamt, ser_in,
                  output out, cy, busy, done);
endinterface

// File: rtl/ureg_shift_step.sv
// Combinational single-bit shift/rotate step; bit_o is the bit that falls off the end.
module ureg_shift_step
  import ureg_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] val_i,
  input  op_t                   op_i,
  input  logic                  ser_i,
  output logic [DATA_WIDTH-1:0] val_o,
  output logic                  bit_o
);
  localparam int W = DATA_WIDTH;

  always_comb begin
    val_o = val_i;
    bit_o = 1'b0;
    case (op_i)
      OP_SHL: begin val_o = {val_i[W-2:0], ser_i};      bit_o = val_i[W-1]; end
      OP_SHR: begin val_o = {ser_i, val_i[W-1:1]};      bit_o = val_i[0];   end
      OP_ASR: begin val_o = {val_i[W-1], val_i[W-1:1]}; bit_o = val_i[0];   end
      OP_ROL: begin val_o = {val_i[W-2:0], val_i[W-1]}; bit_o = val_i[W-1]; end
      OP_ROR: begin val_o = {val_i[0], val_i[W-1:1]};   bit_o = val_i[0];   end
      default: ;
    endcase
  end
endmodule

// File: rtl/universal_register.sv
// Width-parametrised counter/shifter register: single-cycle INC/DEC/NOP, one-bit-per-clock shifts.
module universal_register
  import ureg_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH+1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  universal_register_if.slave  bus
);
  localparam int W = DATA_WIDTH;

  state_e                 state_q, state_d;
  logic [W-1:0]           out_q, out_d;
  logic                   cy_q, cy_d;
  logic                   done_q, done_d;
  logic [SHAMT_WIDTH-1:0] cnt_q, cnt_d;
  op_t                    op_q, op_d;
  logic [W-1:0]           step_val;
  logic                   step_bit;

  ureg_shift_step #(.DATA_WIDTH(W)) u_step (
    .val_i (out_q),
    .op_i  (op_q),
    .ser_i (bus.ser_in),
    .val_o (step_val),
    .bit_o (step_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
      cy_q    <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      op_q    <= OP_INC;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      cy_q    <= cy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    cy_d    = cy_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    done_d  = 1'b0;
    if (bus.cl) begin
      state_d = ST_IDLE;
      out_d   = '0;
      cy_d    = 1'b0;
      cnt_d   = '0;
    end else if (bus.ld) begin
      state_d = ST_IDLE;
      out_d   = bus.in;
      cy_d    = 1'b0;
    end else if (bus.start && state_q == ST_IDLE) begin
      op_d   = bus.op;
      done_d = 1'b1;
      case (bus.op)
        OP_INC: begin out_d = out_q + W'(1); cy_d = &out_q;  end
        OP_DEC: begin out_d = out_q - W'(1); cy_d = ~|out_q; end
        OP_NOP: ;
        default: begin
          // A zero-length shift completes like a single-cycle op.
          if (bus.shamt != '0) begin
            done_d  = 1'b0;
            cnt_d   = bus.shamt;
            state_d = ST_SHIFT;
          end
        end
      endcase
    end else if (state_q == ST_SHIFT) begin
      out_d = step_val;
      cy_d  = step_bit;
      cnt_d = cnt_q - SHAMT_WIDTH'(1);
      if (cnt_q == SHAMT_WIDTH'(1)) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
    end
  end

  assign bus.out  = out_q;
  assign bus.cy   = cy_q;
  assign bus.busy = (state_q == ST_SHIFT);
  assign bus.done = done_q;
endmodule

// File: doc/universal_register.md
# universal_register

Parametrised successor of the basic control register: a width-parametrised data register with synchronous clear/load, single-cycle wrap-around increment/decrement with a carry/borrow flag, and multi-cycle shift/rotate by a programmable amount. Multi-cycle shifts run one bit per clock under a start/busy/done handshake. The block sits in the datapath wherever a counter, shifter or accumulator register with a status flag is needed.

## Interface
Parameters:
- DATA_WIDTH, 16, register width (≥2)
- SHAMT_WIDTH, $clog2(DATA_WIDTH+1), width of shift-amount input

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- cl  in  1  synchronous clear; highest priority
- ld  in  1  synchronous load of `in`
- in  in  DATA_WIDTH  load data
- start  in  1  request operation `op`; accepted only when busy=0
- op  in  3  operation code, sampled on acceptance
- shamt  in  SHAMT_WIDTH  shift/rotate amount, sampled on acceptance
- ser_in  in  1  fill bit for SHL/SHR, sampled on every shifting edge
- out  out  DATA_WIDTH  register contents
- cy  out  1  carry/borrow/last-bit-out flag
- busy  out  1  multi-cycle shift in progress
- done  out  1  one-cycle completion pulse

## Operation
- Reset: out=0, cy=0, busy=0, done=0, step counter=0, latched op=INC.
- Priority per edge: cl > ld > start-acceptance > shift step.
- cl: out=0, cy=0, busy=0, counter=0; aborts any running shift; done=0.
- ld: out=in, cy=0, busy=0; aborts any running shift; done=0.
- start with busy=1 is ignored (no effect, no error).
- Op codes: 0 INC, 1 DEC, 2 SHL, 3 SHR, 4 ASR, 5 ROL, 6 ROR, 7 NOP.
- INC: out=out+1 mod 2^DATA_WIDTH; cy=1 iff old out was all-ones, else 0.
- DEC: out=out−1 mod 2^DATA_WIDTH; cy=1 iff old out was zero, else 0.
- NOP: out and cy unchanged; done still pulses.
- Shift ops, one bit per step:
  - SHL: {out[W−2:0], ser_in}, cy=old out[W−1]
  - SHR: {ser_in, out[W−1:1]}, cy=old out[0]
  - ASR: {out[W−1], out[W−1:1]}, cy=old out[0]
  - ROL: {out[W−2:0], out[W−1]}, cy=old out[W−1]
  - ROR: {out[0], out[W−1:1]}, cy=old out[0]
- Shift of k steps: counter loaded with shamt on acceptance; each busy edge performs one step and decrements counter.
- shamt values > DATA_WIDTH are legal: shifts saturate to fill pattern, rotates wrap modulo width.
- shamt=0: no step, out/cy unchanged, done pulses, busy never asserted.
- cy is otherwise held between operations.

## Timing
- Acceptance edge N (start=1, busy=0, cl=ld=0).
- INC/DEC/NOP/shift with shamt=0: result visible after edge N; done=1 for the cycle after N; busy stays 0. Back-to-back start every cycle is legal (one op per clock).
- Shift with shamt=k≥1: busy=1 after edge N; steps on edges N+1…N+k; busy=0 and done=1 in the cycle after edge N+k; out is final when done=1.
- done is registered, high exactly one cycle, never concurrent with busy=1.
- A new start may be accepted in the done cycle.
- Asynchronous reset mid-shift: immediate return to reset values; no done.

## Structure
- Shared package `ureg_pkg`: op-code localparams (OP_INC … OP_NOP) and op width constant (3).
- One sub-module is natural: `ureg_shift_step`, combinational one-bit shift/rotate step taking (value, op, ser_in) and returning (next value, bit out). Top holds out, cy, counter, latched op, busy/done FSM (IDLE, SHIFT).

## Test plan
- Reset then INC on out=16'hFFFF (after ld) -> out=16'h0000, cy=1, done one cycle after edge, busy never high.
- ld 16'h0000, DEC -> out=16'hFFFF, cy=1; DEC again -> 16'hFFFE, cy=0.
- ld 16'h8001, ASR shamt=3 -> busy for 3 cycles, out=16'hF000, cy=0, done single pulse.
- ld 16'h8001, ROL shamt=17 -> 17 busy cycles, out=16'h0003, cy=1.
- SHR shamt=8 on 16'hABCD with ser_in=1; assert cl at step 4 -> out=0, busy=0, no done; start during busy ignored.
- SHL shamt=0 -> done next cycle, out/cy unchanged; async rst_n low mid-shift -> all outputs 0 immediately.
